// File: rtl/aes_core.sv
// aes_core: iterative AES-128 encryptor, UNROLL rounds per clock, valid/ready on both sides.
// Optional macro AES_CORE_ABORT_EN adds an abort input that drops the block in flight.
module aes_core #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_plaintext,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_cipher,
`ifdef AES_CORE_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy
);
  localparam int unsigned N_ITER = 10 / UNROLL;
  // counter value during the cycle whose last unrolled round is round 10
  localparam logic [3:0] LAST_CNT = 4'(1 + (N_ITER - 1) * UNROLL);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
    $error("aes_core: UNROLL must be 1, 2, 5 or 10");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // byte i sits at [127-8i -: 8]; row = i%4, column = i/4
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        o[127 - 8*(r + 4*c) -: 8] = SBOX[s[127 - 8*(r + 4*((c + r) % 4)) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32*c -: 32];
      o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d, key_q, key_d, cipher_q, cipher_d;
  logic [127:0] rnd_state, rnd_key;
  logic [7:0]   rcon_q, rcon_d, rnd_rcon;
  logic [3:0]   cnt_q, cnt_d;
  logic         accept, abort_now;

`ifdef AES_CORE_ABORT_EN
  assign abort_now = abort && (fsm_q != IDLE);
`else
  assign abort_now = 1'b0;
`endif

  assign in_ready   = reset_n && !abort_now && (fsm_q == IDLE || (fsm_q == DONE && out_ready));
  assign accept     = in_valid && in_ready;
  assign out_valid  = (fsm_q == DONE) && !abort_now;
  assign out_cipher = cipher_q;
  assign busy       = (fsm_q != IDLE);

  always_comb begin
    rnd_state = state_q;
    rnd_key   = key_q;
    rnd_rcon  = rcon_q;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      rnd_key   = next_key(rnd_key, rnd_rcon);
      rnd_rcon  = xtime(rnd_rcon);
      rnd_state = sub_shift(rnd_state);
      if (cnt_q + 4'(i) != 4'd10) rnd_state = mix_columns(rnd_state);
      rnd_state = rnd_state ^ rnd_key;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    key_d    = key_q;
    rcon_d   = rcon_q;
    cnt_d    = cnt_q;
    cipher_d = cipher_q;
    case (fsm_q)
      IDLE: ;
      RUN: begin
        state_d = rnd_state;
        key_d   = rnd_key;
        rcon_d  = rnd_rcon;
        if (cnt_q == LAST_CNT) begin
          fsm_d    = DONE;
          cipher_d = rnd_state;
        end else begin
          cnt_d = cnt_q + 4'(UNROLL);
        end
      end
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    if (accept) begin
      fsm_d   = RUN;
      state_d = in_plaintext ^ in_key;
      key_d   = in_key;
      rcon_d  = 8'h01;
      cnt_d   = 4'd1;
    end
    // abort beats completion: a block finishing on the abort cycle never reaches out_cipher
    if (abort_now) begin
      fsm_d    = IDLE;
      cipher_d = cipher_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      key_q    <= '0;
      rcon_q   <= '0;
      cnt_q    <= '0;
      cipher_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      key_q    <= key_d;
      rcon_q   <= rcon_d;
      cnt_q    <= cnt_d;
      cipher_q <= cipher_d;
    end
  end

endmodule

// File: tb/tb_aes_core.sv
// tb_aes_core: scoreboard bench for aes_core against an independent byte-level AES model.
module tb_aes_core;
  parameter int unsigned UNROLL = 1;
  localparam int N_ITER = 10 / UNROLL;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clock = 1'b0;
  logic         reset_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_plaintext, in_key, out_cipher;
  logic [2:0]   lat_valid, lat_ready, lat_busy;
  logic [127:0] lat_cipher [3];
`ifdef AES_CORE_ABORT_EN
  logic         abort;
`endif

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  logic [127:0] sb_q [$];
  int           acc_q [$];
  logic [7:0]   sbox_t [256];
  logic         prev_valid = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  aes_core #(.UNROLL(UNROLL)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_plaintext (in_plaintext),
    .in_key       (in_key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_cipher   (out_cipher),
`ifdef AES_CORE_ABORT_EN
    .abort        (abort),
`endif
    .busy         (busy)
  );

  for (genvar k = 0; k < 3; k++) begin : g_lat
    localparam int unsigned U = (k == 0) ? 2 : (k == 1) ? 5 : 10;
    aes_core #(.UNROLL(U)) u_dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (lat_ready[k]),
      .in_plaintext (in_plaintext),
      .in_key       (in_key),
      .out_valid    (lat_valid[k]),
      .out_ready    (out_ready),
      .out_cipher   (lat_cipher[k]),
`ifdef AES_CORE_ABORT_EN
      .abort        (abort),
`endif
      .busy         (lat_busy[k])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box built from the GF(2^8) inverse and the affine map
  task automatic init_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [31:0]  w [4];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      t = {sbox_t[w[3][23:16]], sbox_t[w[3][15:8]], sbox_t[w[3][7:0]], sbox_t[w[3][31:24]]}
          ^ {rc, 24'h0};
      w[0] = w[0] ^ t; w[1] = w[1] ^ w[0]; w[2] = w[2] ^ w[1]; w[3] = w[3] ^ w[2];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) tmp[i] = sbox_t[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r2 = 0; r2 < 4; r2++) st[4*c + r2] = tmp[4*((c + r2) % 4) + r2];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // monitor: latency on every rising out_valid, scoreboard pop on every handshake
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid)
        check("latency", 128'(acc_q.size() != 0 ? cyc - acc_q[0] : 0), 128'(N_ITER + 1));
      if (out_valid && out_ready) begin
        check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
        if (sb_q.size() != 0) begin
          check("cipher", out_cipher, sb_q.pop_front());
          acc_q.delete(0);
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // offers a block, waits (bounded) for the accept edge, leaves in_valid high
  task automatic send(input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] exp, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    in_plaintext = pt;
    in_key = key;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 60) begin
      step();
      #1;
      n++;
    end
    check("accept", 128'(in_ready), 128'(1));
    if (in_ready) begin
      sb_q.push_back(exp);
      acc_q.push_back(cyc);
      acc_cyc = cyc;
    end
    step();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    check("valid_seen", 128'(out_valid), 128'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("drain", 128'(sb_q.size()), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int acc [8];
    int rise [3];
    int lat_exp [3];
    logic [127:0] pt, key;

    lat_exp = '{6, 3, 2};
    init_sbox();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_plaintext = '0; in_key = '0;
`ifdef AES_CORE_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) step();
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_cipher", out_cipher, 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_lat", 128'({lat_valid, lat_busy, lat_ready}), 128'(0));
    reset_n = 1'b1;
    #1;
    check("idle_ready", 128'(in_ready), 128'(1));
    check("lat_idle_ready", 128'(lat_ready), 128'(3'b111));

    // C.1 on all unroll factors at once
    out_ready = 1'b1;
    send(C1_PT, C1_KEY, C1_CT, c0);
    in_valid = 1'b0;
    rise = '{-1, -1, -1};
    for (int n = 0; n < 15; n++) begin
      for (int k = 0; k < 3; k++)
        if (lat_valid[k] && rise[k] < 0) begin
          rise[k] = cyc;
          check("lat_cipher", lat_cipher[k], C1_CT);
        end
      step();
    end
    for (int k = 0; k < 3; k++) check("lat_latency", 128'(rise[k] - c0), 128'(lat_exp[k]));
    drain();

    // backpressure, then consume-and-load on the same edge
    out_ready = 1'b0;
    send(C1_PT, C1_KEY, C1_CT, c0);
    in_valid = 1'b0;
    wait_valid();
    for (int n = 0; n < 20; n++) begin
      check("bp_cipher", out_cipher, C1_CT);
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_valid", 128'(out_valid), 128'(1));
      step();
    end
    out_ready = 1'b1;
    send(B_PT, B_KEY, B_CT, c0);
    in_valid = 1'b0;
    check("b2b_valid_drop", 128'(out_valid), 128'(0));
    drain();

    // back-to-back random blocks
    for (int i = 0; i < 8; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      send(pt, key, ref_encrypt(pt, key), acc[i]);
    end
    in_valid = 1'b0;
    for (int i = 1; i < 8; i++) check("b2b_gap", 128'(acc[i] - acc[i-1]), 128'(N_ITER + 1));
    drain();

    // reset in the middle of RUN
    send(C1_PT, C1_KEY, C1_CT, c0);
    in_valid = 1'b0;
    for (int n = 0; n < N_ITER / 2 - 1; n++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    sb_q.delete();
    acc_q.delete();
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_cipher", out_cipher, 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check("mid_rst_busy", 128'(busy), 128'(0));
    send(C1_PT, C1_KEY, C1_CT, c0);
    in_valid = 1'b0;
    drain();

`ifdef AES_CORE_ABORT_EN
    // abort at round 3 with a competing offer
    send(C1_PT, C1_KEY, C1_CT, c0);
    in_valid = 1'b0;
    for (int n = 0; n < 2 / int'(UNROLL); n++) step();
    in_plaintext = B_PT;
    in_key = B_KEY;
    in_valid = 1'b1;
    abort = 1'b1;
    #1;
    check("ab_in_ready", 128'(in_ready), 128'(0));
    check("ab_valid", 128'(out_valid), 128'(0));
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    acc_q.delete();
    check("ab_idle", 128'(busy), 128'(0));
    check("ab_valid_after", 128'(out_valid), 128'(0));
    check("ab_cipher_kept", out_cipher, C1_CT);
    send(B_PT, B_KEY, B_CT, c0);
    in_valid = 1'b0;
    drain();
`endif

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
